dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port data memory.
- Port 0 is the CPU load/store stage; port 1 is the debug/loader port.
- Selects one request at a time, drives the memory's `addr`/`writeData`/`memRead`/`memWrite`, holds them for a fixed number of wait cycles, then returns read data or a write acknowledge to the winner.
- Sits between the pipeline's MEM stage and the data memory.

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/dmem_arb_pick.sv | 21 ++
 rtl/dmem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational two-way priority pick. A lone requester always wins; on a
// tie the pointer names the port that has priority (0 = CPU, 1 = debug).
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // One-hot winner selection
  always_comb begin
    gnt = 2'b00;
    if (req[PORT_CPU] && req[PORT_DBG]) begin
      gnt[ptr ? PORT_DBG : PORT_CPU] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter and sequencer for the single-port data memory.
// Port 0 is the CPU MEM stage, port 1 the debug/loader port. One access is
// in flight at a time: grant in IDLE, strobe the memory for WAIT_CYCLES in
// ACCESS, then pulse rvalid to the winner in RESP.
// Optional feature: define DMEM_ARB_ROUND_ROBIN_EN for a round-robin tie
// breaker; otherwise port 0 always wins ties.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int DEPTH       = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic              oor_q, oor_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ptr;
  logic [1:0]        pick_gnt;
  logic              last_cycle;
  logic [ADDR_W-1:0] addr_sel;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

  dmem_arb_pick u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt)
  );

  assign last_cycle = (cnt_q == CNT_W'(WAIT_CYCLES - 1));
  assign addr_sel   = pick_gnt[PORT_DBG] ? addr1 : addr0;

  // Memory address/data come straight from the latched request so they hold
  // their last values outside ACCESS.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

  // Next-state and output decode for the IDLE/ACCESS/RESP sequence
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    we_d      = we_q;
    oor_d     = oor_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    gnt       = 2'b00;
    rvalid    = 2'b00;
    err       = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Reset masks the grant so nothing is accepted while it is asserted.
        if (!reset && (pick_gnt != 2'b00)) begin
          gnt     = pick_gnt;
          win_d   = pick_gnt[PORT_DBG];
          we_d    = pick_gnt[PORT_DBG] ? we[PORT_DBG] : we[PORT_CPU];
          addr_d  = addr_sel;
          wdata_d = pick_gnt[PORT_DBG] ? wdata1 : wdata0;
          oor_d   = (addr_sel >= ADDR_W'(DEPTH));
          cnt_d   = '0;
          state_d = ST_ACCESS;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
          ptr_d   = ~pick_gnt[PORT_DBG];
`endif
        end
      end

      ST_ACCESS: begin
        // Out-of-range accesses keep their timing but never touch memory.
        mem_read  = ~we_q & ~oor_q;
        mem_write = we_q & ~oor_q & last_cycle;
        if (last_cycle) begin
          rdata_d = (we_q || oor_q) ? '0 : mem_rdata;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        rvalid  = win_q ? 2'b10 : 2'b01;
        err     = oor_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and request latches
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      we_q    <= we_d;
      oor_q   <= oor_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // Round-robin priority pointer, starts with the CPU port
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: two instances (WAIT_CYCLES 1 and 3),
// each with a small behavioural memory.
module tb_dmem_arbiter;

  typedef struct {
    logic [1:0]  rv;
    logic [31:0] rd;
    logic        er;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        init_s;

  logic [1:0]  req_s    [2];
  logic [1:0]  we_s     [2];
  logic [31:0] addr0_s  [2];
  logic [31:0] addr1_s  [2];
  logic [31:0] wdata0_s [2];
  logic [31:0] wdata1_s [2];

  logic [1:0]  gnt_w       [2];
  logic [1:0]  rvalid_w    [2];
  logic [31:0] rdata_w     [2];
  logic        err_w       [2];
  logic [31:0] mem_addr_w  [2];
  logic [31:0] mem_wdata_w [2];
  logic        mem_read_w  [2];
  logic        mem_write_w [2];
  logic [31:0] mem_rdata_w [2];

  logic [31:0] mem [2][32];

  exp_t q0[$];
  exp_t q1[$];

  int ntests = 0;
  int nfail  = 0;
  int last_gwait;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_arbiter #(
      .WAIT_CYCLES ((g == 0) ? 1 : 3),
      .DEPTH       (32)
    ) u_dut (
      .clock     (clk),
      .reset     (reset),
      .req       (req_s[g]),
      .we        (we_s[g]),
      .addr0     (addr0_s[g]),
      .addr1     (addr1_s[g]),
      .wdata0    (wdata0_s[g]),
      .wdata1    (wdata1_s[g]),
      .gnt       (gnt_w[g]),
      .rvalid    (rvalid_w[g]),
      .rdata     (rdata_w[g]),
      .err       (err_w[g]),
      .mem_addr  (mem_addr_w[g]),
      .mem_wdata (mem_wdata_w[g]),
      .mem_read  (mem_read_w[g]),
      .mem_write (mem_write_w[g]),
      .mem_rdata (mem_rdata_w[g])
    );

    assign mem_rdata_w[g] = mem[g][mem_addr_w[g][4:0]];

    always @(posedge clk) begin
      if (init_s) begin
        for (int k = 0; k < 32; k++) begin
          mem[g][k] <= (k == 7) ? 32'h15 : (32'hA000_0000 + 32'(k));
        end
      end else if (mem_write_w[g]) begin
        mem[g][mem_addr_w[g][4:0]] <= mem_wdata_w[g];
      end
    end

    always @(negedge clk) begin
      exp_t e;
      bit   have;
      if (rvalid_w[g] != 2'b00) begin
        have = 1'b0;
        e = '{2'b00, 32'h0, 1'b0};
        if (g == 0) begin
          if (q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
        end else begin
          if (q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
        end
        if (!have) begin
          check($sformatf("unexpected_rvalid_dut%0d", g), 32'(rvalid_w[g]), 32'h0);
        end else begin
          check($sformatf("rvalid_dut%0d", g), 32'(rvalid_w[g]), 32'(e.rv));
          check($sformatf("rdata_dut%0d", g), rdata_w[g], e.rd);
          check($sformatf("err_dut%0d", g), 32'(err_w[g]), 32'(e.er));
        end
      end
    end
  end

  task automatic push_exp(input int i, input logic [1:0] rv, input logic [31:0] rd, input logic er);
    exp_t e;
    e = '{rv, rd, er};
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic wait_gnt(input int i);
    last_gwait = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      last_gwait = k;
      if (gnt_w[i] != 2'b00) break;
    end
  endtask

  task automatic check_idle_zero(input int i, input string tag);
    check({tag, "_gnt"},       32'(gnt_w[i]),       32'h0);
    check({tag, "_rvalid"},    32'(rvalid_w[i]),    32'h0);
    check({tag, "_rdata"},     rdata_w[i],          32'h0);
    check({tag, "_err"},       32'(err_w[i]),       32'h0);
    check({tag, "_mem_read"},  32'(mem_read_w[i]),  32'h0);
    check({tag, "_mem_write"}, 32'(mem_write_w[i]), 32'h0);
    check({tag, "_mem_addr"},  mem_addr_w[i],       32'h0);
    check({tag, "_mem_wdata"}, mem_wdata_w[i],      32'h0);
  endtask

  // One complete transaction on instance i, port p; request dropped after grant.
  task automatic access(input int i, input int p, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] erd, input logic eer,
                        input logic [1:0] eg, input string tag);
    int wc;
    int nrd;
    int nwr;
    int lat;
    wc = (i == 0) ? 1 : 3;
    we_s[i][p] = w;
    if (p == 0) begin addr0_s[i] = a; wdata0_s[i] = d; end
    else begin addr1_s[i] = a; wdata1_s[i] = d; end
    req_s[i][p] = 1'b1;
    wait_gnt(i);
    check({tag, "_gnt"}, 32'(gnt_w[i]), 32'(eg));
    push_exp(i, eg, erd, eer);
    @(posedge clk); #1;
    req_s[i][p] = 1'b0;
    if (p == 0) begin addr0_s[i] = 32'h1F; wdata0_s[i] = 32'hBAD0_BAD0; end
    else begin addr1_s[i] = 32'h1F; wdata1_s[i] = 32'hBAD1_BAD1; end
    nrd = 0;
    nwr = 0;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (rvalid_w[i] != 2'b00) break;
      nrd += int'(mem_read_w[i]);
      nwr += int'(mem_write_w[i]);
    end
    check({tag, "_latency"},   32'(lat), 32'(wc + 1));
    check({tag, "_read_cyc"},  32'(nrd), (w || eer) ? 32'h0 : 32'(wc));
    check({tag, "_write_cyc"}, 32'(nwr), (w && !eer) ? 32'h1 : 32'h0);
    @(posedge clk); #1;
  endtask

  logic [1:0] eg_tab [3];

  initial begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    eg_tab[0] = 2'b01; eg_tab[1] = 2'b10; eg_tab[2] = 2'b01;
`else
    eg_tab[0] = 2'b01; eg_tab[1] = 2'b01; eg_tab[2] = 2'b01;
`endif
    reset  = 1'b1;
    init_s = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_s[i] = 2'b00; we_s[i] = 2'b00;
      addr0_s[i] = 32'h0; addr1_s[i] = 32'h0;
      wdata0_s[i] = 32'h0; wdata1_s[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero(0, "rst0");
    check_idle_zero(1, "rst1");
    @(posedge clk); #1;
    reset  = 1'b0;
    init_s = 1'b0;

    // Single read of word 7 (0x15), WAIT_CYCLES = 1
    access(0, 0, 1'b0, 32'd7, 32'h0, 32'h15, 1'b0, 2'b01, "rd7");

    // Debug port writes then reads back word 3
    access(0, 1, 1'b1, 32'd3, 32'hDEAD_BEEF, 32'h0, 1'b0, 2'b10, "wr3");
    access(0, 1, 1'b0, 32'd3, 32'h0, 32'hDEAD_BEEF, 1'b0, 2'b10, "rd3");

    // Out-of-range read, then mem_addr holds the last latched address
    access(0, 0, 1'b0, 32'd40, 32'h0, 32'h0, 1'b1, 2'b01, "oor40");
    @(negedge clk);
    check("oor_addr_hold", mem_addr_w[0], 32'd40);
    @(posedge clk); #1;

    // Contention: both ports hold req for three transactions
    we_s[0] = 2'b00; addr0_s[0] = 32'd1; addr1_s[0] = 32'd2;
    req_s[0] = 2'b11;
    for (int t = 0; t < 3; t++) begin
      wait_gnt(0);
      check($sformatf("cont_gnt%0d", t), 32'(gnt_w[0]), 32'(eg_tab[t]));
      push_exp(0, eg_tab[t], eg_tab[t][1] ? 32'hA000_0002 : 32'hA000_0001, 1'b0);
      @(posedge clk); #1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (rvalid_w[0] != 2'b00) break;
      end
      if (t == 2) req_s[0] = 2'b00;
      @(posedge clk); #1;
    end

    // WAIT_CYCLES = 3: port 1 read with port 0 we set but not requesting
    we_s[1] = 2'b01;
    access(1, 1, 1'b0, 32'd9, 32'h0, 32'hA000_0009, 1'b0, 2'b10, "w3_rd9");
    access(1, 0, 1'b1, 32'd4, 32'h1234_5678, 32'h0, 1'b0, 2'b01, "w3_wr4");
    access(1, 0, 1'b0, 32'd4, 32'h0, 32'h1234_5678, 1'b0, 2'b01, "w3_rd4");

    // Reset during the second ACCESS cycle, request left pending
    we_s[1] = 2'b00; addr0_s[1] = 32'd5; req_s[1] = 2'b01;
    wait_gnt(1);
    check("mid_rst_gnt", 32'(gnt_w[1]), 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_idle_zero(1, "mid_rst");
    @(posedge clk); #1;
    reset = 1'b0;
    access(1, 0, 1'b0, 32'd5, 32'h0, 32'hA000_0005, 1'b0, 2'b01, "post_rst");
    check("post_rst_gnt_wait", 32'(last_gwait), 32'h1);

    repeat (3) @(posedge clk);
    check("q0_left", 32'(q0.size()), 32'h0);
    check("q1_left", 32'(q1.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
